// File: rtl/multi_object_frame_encoder.sv
// Sequences enabled sprite objects through the image rotator and writes each rotated pixel to SRAM.
// Optional SKIP_UNCHANGED_EN: objects whose angle matches their last fully written angle are skipped.
module multi_object_frame_encoder #(
  parameter int NUM_OBJECTS = 2,
  parameter int IMAGE_SIZE  = 32,
  parameter int ANG_WIDTH   = 9,
  parameter int COLOR_WIDTH = 4,
  parameter int ADDR_WIDTH  = 20,
  parameter int OBJ_W       = (NUM_OBJECTS > 1) ? $clog2(NUM_OBJECTS) : 1
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_start,
  input  logic                             i_abort,
  input  logic [NUM_OBJECTS-1:0]           i_obj_en,
  input  logic [NUM_OBJECTS*ANG_WIDTH-1:0] i_angles,
  output logic                             o_rot_start,
  output logic [ANG_WIDTH-1:0]             o_rot_angle,
  output logic [OBJ_W-1:0]                 o_rot_obj_sel,
  input  logic                             i_rot_valid,
  input  logic [COLOR_WIDTH-1:0]           i_rot_pixel,
  input  logic                             i_rot_opacity,
  output logic                             o_rot_ready,
  output logic                             o_sram_we,
  output logic [ADDR_WIDTH-1:0]            o_sram_addr,
  output logic [COLOR_WIDTH:0]             o_sram_data,
  input  logic                             i_sram_ready,
  output logic [OBJ_W-1:0]                 o_object_id,
  output logic [2*$clog2(IMAGE_SIZE)-1:0]  o_pixel_counter,
  output logic                             o_busy,
  output logic                             o_done
);
  localparam int PIX_W = 2 * $clog2(IMAGE_SIZE);

  typedef enum logic [2:0] {IDLE, LOAD, STREAM, NEXT, DONE} state_t;
  state_t state, state_nxt;

  logic [NUM_OBJECTS-1:0]           mask_q;
  logic [NUM_OBJECTS*ANG_WIDTH-1:0] angles_q;
  logic [OBJ_W-1:0]                 object_id;
  logic [PIX_W-1:0]                 pixel_counter;
  logic                             sram_we;
  logic [ADDR_WIDTH-1:0]            sram_addr;
  logic [COLOR_WIDTH:0]             sram_data;
  logic                             last_pend;
  logic [NUM_OBJECTS-1:0]           start_mask;
  logic                             first_found, next_found;
  logic [OBJ_W-1:0]                 first_idx, next_idx;
  logic                             accept, drain, last_pix, abort;

  assign abort       = i_abort && (state != IDLE);
  assign o_rot_ready = (state == STREAM) && (!sram_we || i_sram_ready);
  assign accept      = i_rot_valid && o_rot_ready;
  assign drain       = sram_we && i_sram_ready;
  assign last_pix    = &pixel_counter;

`ifdef SKIP_UNCHANGED_EN
  logic [NUM_OBJECTS*ANG_WIDTH-1:0] stored_ang;
  logic [NUM_OBJECTS-1:0]           stored_vld;

  always_comb begin
    start_mask = i_obj_en;
    for (int k = 0; k < NUM_OBJECTS; k++) begin
      if (stored_vld[k] && (stored_ang[k*ANG_WIDTH +: ANG_WIDTH] == i_angles[k*ANG_WIDTH +: ANG_WIDTH]))
        start_mask[k] = 1'b0;
    end
  end

  // An object's angle is remembered only once its final pixel has actually reached SRAM.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      stored_ang <= '0;
      stored_vld <= '0;
    end else if (abort) begin
      stored_vld <= '0;
    end else if (drain && last_pend) begin
      stored_ang[object_id*ANG_WIDTH +: ANG_WIDTH] <= angles_q[object_id*ANG_WIDTH +: ANG_WIDTH];
      stored_vld[object_id]                        <= 1'b1;
    end
  end
`else
  assign start_mask = i_obj_en;
`endif

  always_comb begin
    first_found = 1'b0;
    first_idx   = '0;
    next_found  = 1'b0;
    next_idx    = '0;
    for (int k = NUM_OBJECTS - 1; k >= 0; k--) begin
      if (start_mask[k]) begin
        first_found = 1'b1;
        first_idx   = OBJ_W'(k);
      end
      if (mask_q[k] && (k > int'(object_id))) begin
        next_found = 1'b1;
        next_idx   = OBJ_W'(k);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (i_start) state_nxt = first_found ? LOAD : DONE;
        LOAD:    state_nxt = STREAM;
        STREAM:  if (accept && last_pix) state_nxt = NEXT;
        NEXT:    if (!sram_we) state_nxt = next_found ? LOAD : DONE;
        DONE:    if (!i_start) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mask_q        <= '0;
      angles_q      <= '0;
      object_id     <= '0;
      pixel_counter <= '0;
      sram_we       <= 1'b0;
      sram_addr     <= '0;
      sram_data     <= '0;
      last_pend     <= 1'b0;
    end else if (abort) begin
      object_id     <= '0;
      pixel_counter <= '0;
      sram_we       <= 1'b0;
      last_pend     <= 1'b0;
    end else begin
      // Accept overrides drain: the register refills in the same cycle it empties.
      if (accept) begin
        sram_we       <= 1'b1;
        sram_addr     <= ADDR_WIDTH'({object_id, pixel_counter});
        sram_data     <= {i_rot_opacity, i_rot_pixel};
        pixel_counter <= pixel_counter + 1'b1;
        last_pend     <= last_pix;
      end else if (drain) begin
        sram_we   <= 1'b0;
        last_pend <= 1'b0;
      end
      case (state)
        IDLE: if (i_start) begin
          mask_q    <= start_mask;
          angles_q  <= i_angles;
          object_id <= first_idx;
        end
        LOAD:    pixel_counter <= '0;
        NEXT:    if (!sram_we && next_found) object_id <= next_idx;
        default: ;
      endcase
    end
  end

  assign o_rot_start     = (state == LOAD);
  assign o_rot_angle     = angles_q[object_id*ANG_WIDTH +: ANG_WIDTH];
  assign o_rot_obj_sel   = object_id;
  assign o_sram_we       = sram_we;
  assign o_sram_addr     = sram_addr;
  assign o_sram_data     = sram_data;
  assign o_object_id     = object_id;
  assign o_pixel_counter = pixel_counter;
  assign o_busy          = (state == LOAD) || (state == STREAM) || (state == NEXT);
  assign o_done          = (state == DONE);
endmodule

// File: tb/tb_multi_object_frame_encoder.sv
// Bench for multi_object_frame_encoder: rotator/SRAM stubs, write-order scoreboard and directed frames.
module tb_multi_object_frame_encoder;
  localparam int N = 3, IS = 32, NPIX = IS * IS, AW = 9, CW = 4, ADW = 20, OW = 2, PW = 10;

  logic clk = 1'b0;
  logic rst, i_start, i_abort;
  logic [N-1:0]    i_obj_en;
  logic [N*AW-1:0] i_angles;
  logic            o_rot_start, i_rot_valid, i_rot_opacity, o_rot_ready;
  logic [AW-1:0]   o_rot_angle;
  logic [OW-1:0]   o_rot_obj_sel, o_object_id;
  logic [CW-1:0]   i_rot_pixel;
  logic            o_sram_we, i_sram_ready, o_busy, o_done;
  logic [ADW-1:0]  o_sram_addr;
  logic [CW:0]     o_sram_data;
  logic [PW-1:0]   o_pixel_counter;

  always #5 clk = ~clk;

  multi_object_frame_encoder #(.NUM_OBJECTS(N), .IMAGE_SIZE(IS), .ANG_WIDTH(AW),
                               .COLOR_WIDTH(CW), .ADDR_WIDTH(ADW)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(i_start), .i_abort(i_abort),
    .i_obj_en(i_obj_en), .i_angles(i_angles),
    .o_rot_start(o_rot_start), .o_rot_angle(o_rot_angle), .o_rot_obj_sel(o_rot_obj_sel),
    .i_rot_valid(i_rot_valid), .i_rot_pixel(i_rot_pixel), .i_rot_opacity(i_rot_opacity),
    .o_rot_ready(o_rot_ready), .o_sram_we(o_sram_we), .o_sram_addr(o_sram_addr),
    .o_sram_data(o_sram_data), .i_sram_ready(i_sram_ready), .o_object_id(o_object_id),
    .o_pixel_counter(o_pixel_counter), .o_busy(o_busy), .o_done(o_done));

  int n_checks = 0, n_fail = 0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Pixel content the rotator stub emits for (object, pixel index).
  function automatic logic [CW:0] pix(input int obj, input int p);
    logic [CW-1:0] c;
    c = CW'((obj * 5 + p) % 16);
    return {p[0] ^ obj[0], c};
  endfunction

  typedef struct {int addr; int data; int obj; bit last;} wr_t;
  wr_t exp_q[$];
  logic [AW-1:0] cur_ang[N];
  logic [AW-1:0] st_ang[N];
  bit            st_vld[N];
  int wr_count, rs_count, first_addr, last_addr;
  int sel_seq[$];
  int stall_at = -1, stall_left = 0, stall_hits = 0;

  // Expected write stream: every enabled (and, when skipping, changed) object in index order.
  function automatic void build(input logic [N-1:0] en);
    bit skip;
    for (int k = 0; k < N; k++) begin
      skip = 1'b0;
`ifdef SKIP_UNCHANGED_EN
      skip = st_vld[k] && (st_ang[k] == cur_ang[k]);
`endif
      if (en[k] && !skip)
        for (int p = 0; p < NPIX; p++)
          exp_q.push_back('{k * NPIX + p, int'(pix(k, p)), k, p == NPIX - 1});
    end
  endfunction

  // Rotator stub: after each start pulse, streams NPIX pixels with random bubbles.
  initial begin
    bit acc, st, act;
    int sel, r_obj, r_p;
    act = 0; r_obj = 0; r_p = 0;
    i_rot_valid = 0; i_rot_pixel = 0; i_rot_opacity = 0;
    forever begin
      @(negedge clk);
      acc = i_rot_valid && o_rot_ready;
      st  = o_rot_start;
      sel = int'(o_rot_obj_sel);
      @(posedge clk); #1;
      if (st) begin act = 1; r_obj = sel; r_p = 0; end
      else if (acc) begin r_p++; if (r_p == NPIX) act = 0; end
      if (act && $urandom_range(0, 4) != 0) begin
        i_rot_valid = 1'b1;
        {i_rot_opacity, i_rot_pixel} = pix(r_obj, r_p);
      end else begin
        i_rot_valid = 1'b0;
      end
    end
  end

  // SRAM stub: always ready, except a single 5-cycle stall once wr_count reaches stall_at.
  initial begin
    i_sram_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (stall_left > 0) begin
        i_sram_ready = 1'b0;
        stall_left--;
      end else begin
        i_sram_ready = 1'b1;
        if (stall_at >= 0 && wr_count >= stall_at) begin
          stall_at = -1; stall_left = 4; stall_hits++;
          i_sram_ready = 1'b0;
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the scoreboard.
  initial begin
    bit p_we, p_rdy, p_abort;
    logic [ADW-1:0] p_addr;
    logic [CW:0] p_data;
    wr_t e;
    p_we = 0; p_rdy = 1; p_abort = 0; p_addr = 0; p_data = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (p_we && !p_rdy && !p_abort) begin
          check("hold_we", o_sram_we, 1);
          check("hold_addr", o_sram_addr, p_addr);
          check("hold_data", o_sram_data, p_data);
        end
        if (o_sram_we && !i_sram_ready) check("ready_low_when_full", o_rot_ready, 0);
        check("busy_done_exclusive", o_busy & o_done, 0);
        if (o_rot_start) begin
          rs_count++;
          sel_seq.push_back(int'(o_rot_obj_sel));
          check("rot_angle", o_rot_angle, cur_ang[o_rot_obj_sel]);
        end
        if (o_sram_we && i_sram_ready) begin
          check("write_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("wr_addr", o_sram_addr, e.addr);
            check("wr_data", o_sram_data, e.data);
            if (e.last) begin st_ang[e.obj] = cur_ang[e.obj]; st_vld[e.obj] = 1; end
          end
          if (wr_count == 0) first_addr = int'(o_sram_addr);
          last_addr = int'(o_sram_addr);
          wr_count++;
        end
        if (o_done) check("done_after_all_writes", exp_q.size(), 0);
        if (i_abort && (o_busy || o_done)) begin
          exp_q.delete();
          for (int k = 0; k < N; k++) st_vld[k] = 0;
        end
      end
      p_we = o_sram_we; p_rdy = i_sram_ready; p_abort = i_abort;
      p_addr = o_sram_addr; p_data = o_sram_data;
    end
  end

  task automatic start_frame(input logic [N-1:0] en, input logic [AW-1:0] a0, a1, a2);
    cur_ang[0] = a0; cur_ang[1] = a1; cur_ang[2] = a2;
    i_obj_en = en;
    i_angles = {a2, a1, a0};
    build(en);
    wr_count = 0; rs_count = 0; first_addr = -1; last_addr = -1;
    sel_seq.delete();
    @(posedge clk); #1;
    i_start = 1'b1;
  endtask

  task automatic finish_frame(input int exp_writes, output int dl, output int lat);
    bit seen;
    seen = 0; dl = 0; lat = 0;
    for (int c = 0; c < 20000 && !o_done; c++) begin
      @(negedge clk);
      dl++;
      if (!seen) begin lat++; if (o_rot_start) seen = 1; end
    end
    check("frame_done_reached", o_done, 1);
    check("write_count", wr_count, exp_writes);
    check("queue_drained", exp_q.size(), 0);
    @(posedge clk); #1;
    i_start = 1'b0;
    @(negedge clk);
    check("done_held_while_start_falls", o_done, 1);
    @(negedge clk);
    check("done_cleared", o_done, 0);
  endtask

  initial begin
    int dl, lat;
    bit reached;
    rst = 1'b1; i_start = 0; i_abort = 0; i_obj_en = 0; i_angles = 0;
    for (int k = 0; k < N; k++) begin st_vld[k] = 0; st_ang[k] = 0; cur_ang[k] = 0; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_we", o_sram_we, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_rot_start", o_rot_start, 0);
    check("rst_rot_ready", o_rot_ready, 0);
    check("rst_addr", o_sram_addr, 0);
    check("rst_pix_cnt", o_pixel_counter, 0);
    check("rst_obj_id", o_object_id, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Two objects, full throughput apart from rotator bubbles.
    start_frame(3'b011, 9'd0, 9'd90, 9'd0);
    finish_frame(2048, dl, lat);
    check("t1_start_latency", lat, 2);
    check("t1_rot_start_pulses", rs_count, 2);
    check("t1_first_addr", first_addr, 0);
    check("t1_last_addr", last_addr, 2047);

    // Object 1 disabled: sequence 0 then 2.
    start_frame(3'b101, 9'd10, 9'd20, 9'd30);
    finish_frame(2048, dl, lat);
    check("t2_sel_count", sel_seq.size(), 2);
    if (sel_seq.size() == 2) begin
      check("t2_sel0", sel_seq[0], 0);
      check("t2_sel1", sel_seq[1], 2);
    end
    check("t2_first_addr", first_addr, 0);
    check("t2_last_addr", last_addr, 3071);

    // Empty mask: straight to done one cycle later, no writes.
    start_frame(3'b000, 9'd1, 9'd2, 9'd3);
    finish_frame(0, dl, lat);
    check("t3_done_latency", dl, 2);
    check("t3_rot_start_pulses", rs_count, 0);

    // SRAM stall of 5 cycles mid-stream.
    stall_at = 300;
    start_frame(3'b011, 9'd100, 9'd101, 9'd0);
    finish_frame(2048, dl, lat);
    check("t4_stall_applied", stall_hits, 1);
    check("t4_last_addr", last_addr, 2047);

    // Abort around pixel 500 of object 0, then restart.
    start_frame(3'b011, 9'd7, 9'd8, 9'd0);
    reached = 0;
    for (int c = 0; c < 5000 && !reached; c++) begin
      @(negedge clk);
      reached = (o_object_id == 0) && (o_pixel_counter == 10'd500);
    end
    check("t5_reached_pixel_500", reached, 1);
    @(posedge clk); #1;
    i_abort = 1'b1; i_start = 1'b0;
    @(posedge clk); #1;
    i_abort = 1'b0;
    @(negedge clk);
    check("t5_abort_idle", o_busy, 0);
    check("t5_abort_we", o_sram_we, 0);
    check("t5_abort_pix_cnt", o_pixel_counter, 0);
    for (int c = 0; c < 4; c++) begin
      check("t5_no_done", o_done, 0);
      @(negedge clk);
    end
    start_frame(3'b011, 9'd7, 9'd8, 9'd0);
    finish_frame(2048, dl, lat);
    check("t5_restart_first_addr", first_addr, 0);

    // Repeated angles: skipped when unchanged-skip is built in.
    start_frame(3'b011, 9'd45, 9'd45, 9'd0);
    finish_frame(2048, dl, lat);
`ifdef SKIP_UNCHANGED_EN
    start_frame(3'b011, 9'd45, 9'd45, 9'd0);
    finish_frame(0, dl, lat);
    start_frame(3'b011, 9'd45, 9'd46, 9'd0);
    finish_frame(1024, dl, lat);
    check("t6_first_addr", first_addr, 1024);
    check("t6_last_addr", last_addr, 2047);
`else
    start_frame(3'b011, 9'd45, 9'd45, 9'd0);
    finish_frame(2048, dl, lat);
    start_frame(3'b011, 9'd45, 9'd46, 9'd0);
    finish_frame(2048, dl, lat);
    check("t6_first_addr", first_addr, 0);
    check("t6_last_addr", last_addr, 2047);
`endif

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/multi_object_frame_encoder.md
Name: multi_object_frame_encoder

Overview:
- Parametrised successor to the two-car frame encoder; sequences N sprite objects through an external image rotator and writes each rotated pixel into SRAM.
- Adds a per-object enable mask, angle/mask snapshot at start, SRAM back-pressure, abort, and object-relative address generation.
- Sits between game logic (angles, enables) and the shared ImageRotator/SRAM write port.

Parameters:
NUM_OBJECTS, 2, number of rotatable objects (1..16)
IMAGE_SIZE, 32, sprite edge length in pixels (power of two)
ANG_WIDTH, 9, signed angle width
COLOR_WIDTH, 4, encoded colour width
ADDR_WIDTH, 20, SRAM address width
OBJ_W, $clog2(NUM_OBJECTS) min 1, object index width

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, asynchronous, active-high
i_start  in  1  level request; frame encode runs while high, acknowledged by o_done
i_abort  in  1  cancel current frame
i_obj_en  in  NUM_OBJECTS  per-object enable mask
i_angles  in  NUM_OBJECTS*ANG_WIDTH  signed angles; object k at bits [k*ANG_WIDTH +: ANG_WIDTH]
o_rot_start  out  1  one-cycle start pulse to rotator
o_rot_angle  out  ANG_WIDTH  latched angle of current object
o_rot_obj_sel  out  OBJ_W  LUT select for rotator
i_rot_valid  in  1  rotator pixel valid
i_rot_pixel  in  COLOR_WIDTH  rotated colour
i_rot_opacity  in  1  pixel opaque flag
o_rot_ready  out  1  encoder can accept a pixel
o_sram_we  out  1  write strobe
o_sram_addr  out  ADDR_WIDTH  write address
o_sram_data  out  COLOR_WIDTH+1  {opacity, colour}
i_sram_ready  in  1  SRAM accepted write this cycle
o_object_id  out  OBJ_W  object being processed
o_pixel_counter  out  2*log2(IMAGE_SIZE)  pixel index within object
o_busy  out  1  high in any state except IDLE/DONE
o_done  out  1  frame complete

Behaviour:
- Reset: all outputs and registers 0; state IDLE.
- States: IDLE, LOAD, STREAM, NEXT, DONE.
- IDLE: on i_start, snapshot i_obj_en and i_angles. If mask == 0 -> DONE; else object_id = lowest enabled index -> LOAD. Snapshot inputs are ignored until the next start.
- LOAD (1 cycle): o_rot_start = 1; o_rot_angle/o_rot_obj_sel hold the latched object. pixel_counter = 0. -> STREAM.
- STREAM: a pixel is accepted when i_rot_valid && o_rot_ready.
  - On accept: register o_sram_we = 1, addr = object_id*IMAGE_SIZE^2 + pixel_counter (zero-extended), data = {i_rot_opacity, i_rot_pixel}; pixel_counter increments.
  - Accepting pixel IMAGE_SIZE^2-1 -> NEXT, with the counter wrapping to 0.
- Write port: one-entry output register; o_rot_ready = !o_sram_we || i_sram_ready (combinational). o_sram_we/addr/data hold stable until i_sram_ready. Accept and drain in the same cycle is allowed, giving 1 pixel/cycle at full throughput.
- NEXT: wait until the write register is empty, then select the next enabled index > object_id. Found -> LOAD; none -> DONE.
- DONE: o_done = 1, o_busy = 0; stay until i_start = 0, then -> IDLE. o_done drops the cycle after i_start falls.
- i_abort in any state other than IDLE: next state IDLE, o_sram_we cleared (pending write dropped), counters zeroed, o_done not asserted. Abort takes priority over all other transitions. Abort in IDLE is ignored.
- i_rot_valid outside STREAM is ignored; o_rot_ready = 0 outside STREAM.
- Latency from i_start to first o_rot_start: 2 cycles (IDLE snapshot, then LOAD).

Optional Feature:
SKIP_UNCHANGED_EN.
- Defined: keeps a per-object register of the last fully written angle, plus a valid bit cleared by reset or abort. An object whose latched angle equals its stored angle (with valid set) is treated as disabled for this frame. The stored angle updates when the object's last pixel drains to SRAM.
- Undefined: every enabled object is always re-rendered; no extra registers.

Test Plan:
- NUM_OBJECTS=2, mask 2'b11, angles 0/90, i_sram_ready=1 -> 2048 writes; addr 0..1023 for object 0 then 1024..2047 for object 1; o_done after last write; o_rot_start pulsed twice.
- Mask 3'b101 (NUM_OBJECTS=3) -> object 1 skipped; addresses 0..1023 and 2048..3071 only; o_rot_obj_sel sequence 0, 2.
- Mask 0 with i_start high -> o_done asserted 1 cycle later, zero writes; dropping i_start clears o_done next cycle.
- i_sram_ready held low 5 cycles mid-stream -> o_rot_ready low, addr/data stable, no pixel lost; final pixel count still 1024 per object.
- i_abort at pixel 500 of object 0 -> next cycle IDLE, o_sram_we=0, o_done never set; a new start restarts at addr 0.
- SKIP_UNCHANGED_EN: two frames with identical angles 45/45 -> second frame yields zero writes and o_done; changing object 1 to 46 -> only addresses 1024..2047 are rewritten.
